// File: rtl/div_pkg.sv
// Shared types and constants for the clock-division controller.
package div_pkg;

  localparam int unsigned DivW        = 32;
  localparam int unsigned DefaultHalf = 50_000_000;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/half_counter.sv
// Half-period counter: counts up to half-1, then wraps, toggling clk_out and pulsing tick.
// Disabling the counter clears it, forcing clk_out low with no tick.
module half_counter
  import div_pkg::*;
#(
  parameter int unsigned W = DivW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] half,
  output logic         wrap,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] cnt_q;

  // half is never 0 (stored as 1), so half-1 cannot underflow.
  assign wrap = en && (cnt_q == (half - One));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      clk_out <= !clk_out;
      tick    <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + One;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Run-time clock-division controller: start/stop FSM, config handshake with shadow
// registers applied only at half-period boundaries, and one-shot completion.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned W            = DivW,
  parameter int unsigned DEFAULT_HALF = DefaultHalf
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_half,
  input  logic         cfg_oneshot,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         clk_out,
  output logic         tick,
  output logic         done
);

  localparam logic [W-1:0] One     = W'(1);
  localparam logic [W-1:0] HalfRst = W'(DEFAULT_HALF);

  state_e       state_q;
  logic [W-1:0] half_q;
  logic [W-1:0] shadow_half_q;
  logic         oneshot_q;
  logic         shadow_oneshot_q;
  logic         pending_q;
  logic [1:0]   edge_cnt_q;
  logic         done_q;

  logic         xfer;
  logic         run;
  logic         wrap;
  logic         last_wrap;
  logic [W-1:0] cfg_half_eff;

  assign cfg_ready    = !pending_q;
  assign busy         = (state_q == StRun);
  assign done         = done_q;
  assign xfer         = cfg_valid && cfg_ready;
  assign cfg_half_eff = (cfg_half == '0) ? One : cfg_half;
  // Stop wins over a coincident wrap: the counter is held clear, so no tick.
  assign run          = busy && !stop;
  // Odd edge count means clk_out is high; this wrap brings it low and ends the one-shot.
  assign last_wrap    = wrap && oneshot_q && edge_cnt_q[0];

  half_counter #(
    .W(W)
  ) u_half_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run),
    .half   (half_q),
    .wrap   (wrap),
    .clk_out(clk_out),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      half_q           <= HalfRst;
      oneshot_q        <= 1'b0;
      shadow_half_q    <= HalfRst;
      shadow_oneshot_q <= 1'b0;
      pending_q        <= 1'b0;
      edge_cnt_q       <= '0;
      done_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (xfer) begin
            half_q    <= cfg_half_eff;
            oneshot_q <= cfg_oneshot;
          end
          if (start && !stop) begin
            state_q    <= StRun;
            edge_cnt_q <= '0;
          end
        end
        StRun: begin
          if (stop || last_wrap) begin
            // Leaving RUN: settle any configuration now so IDLE never holds a pending shadow.
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            pending_q  <= 1'b0;
            done_q     <= last_wrap;
            if (xfer) begin
              half_q    <= cfg_half_eff;
              oneshot_q <= cfg_oneshot;
            end else if (pending_q) begin
              half_q    <= shadow_half_q;
              oneshot_q <= shadow_oneshot_q;
            end
          end else begin
            if (wrap) begin
              edge_cnt_q <= edge_cnt_q + 2'd1;
              if (pending_q) begin
                half_q    <= shadow_half_q;
                oneshot_q <= shadow_oneshot_q;
              end
            end
            // A transfer on a wrap cycle is held until the following wrap.
            if (xfer) begin
              shadow_half_q    <= cfg_half_eff;
              shadow_oneshot_q <= cfg_oneshot;
              pending_q        <= 1'b1;
            end else if (wrap) begin
              pending_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table for free-run ratios, a tick scoreboard,
// and hand-written sequences for reconfiguration, one-shot, stop and reset corners.
module tb_div_ctrl;

  localparam int unsigned W       = 32;
  localparam int          DefHalf = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_half;
  logic         cfg_oneshot;
  logic         start;
  logic         stop;
  logic         busy;
  logic         clk_out;
  logic         tick;
  logic         done;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int   cyc;
    logic clk_out;
    logic done;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [W-1:0] half;
    int           period;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_ctrl #(
    .W           (W),
    .DEFAULT_HALF(DefHalf)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_half   (cfg_half),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .clk_out    (clk_out),
    .tick       (tick),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic co, input logic d);
    ev_t e;
    e.cyc     = c;
    e.clk_out = co;
    e.done    = d;
    exp_q.push_back(e);
  endtask

  // Sample n negedges; every tick must match the head of the scoreboard.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 64'(tick), 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("tick_cycle", 64'(cyc), 64'(e.cyc));
          check("tick_clk_out", 64'(clk_out), 64'(e.clk_out));
          check("tick_done", 64'(done), 64'(e.done));
        end
      end else if (done) begin
        check("done_without_tick", 64'(done), 64'd0);
      end
    end
  endtask

  task automatic cfg_write(input logic [W-1:0] h, input logic os);
    cfg_valid   = 1'b1;
    cfg_half    = h;
    cfg_oneshot = os;
    for (int k = 0; k < 20 && !cfg_ready; k++) @(negedge clk);
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_clk_out", 64'(clk_out), 64'd0);
    check("stop_tick", 64'(tick), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int s2;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_half    = '0;
    cfg_oneshot = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;

    vecs[0] = '{half: 32'd4, period: 4};
    vecs[1] = '{half: 32'd0, period: 1};
    vecs[2] = '{half: 32'd1, period: 1};
    vecs[3] = '{half: 32'd3, period: 3};
    vecs[4] = '{half: 32'd6, period: 6};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_clk_out", 64'(clk_out), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    #1 rst_n = 1'b1;

    // Default half-period after reset
    pulse_start(s);
    push_ev(s + DefHalf, 1'b1, 1'b0);
    observe(DefHalf);
    check("default_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_run();

    // Free-run ratios from the vector table
    for (int i = 0; i < 5; i++) begin
      cfg_write(vecs[i].half, 1'b0);
      pulse_start(s);
      for (int k = 1; k <= 4; k++) push_ev(s + k * vecs[i].period, (k % 2) == 1, 1'b0);
      observe(4 * vecs[i].period);
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      check("vec_busy", 64'(busy), 64'd1);
      stop_run();
    end

    // Reconfigure mid half-period: 4 -> 2, applied at the next wrap
    cfg_write(32'd4, 1'b0);
    pulse_start(s);
    push_ev(s + 4, 1'b1, 1'b0);
    push_ev(s + 6, 1'b0, 1'b0);
    push_ev(s + 8, 1'b1, 1'b0);
    push_ev(s + 10, 1'b0, 1'b0);
    observe(1);
    cfg_valid = 1'b1;
    cfg_half  = 32'd2;
    observe(1);
    cfg_valid = 1'b0;
    check("reconf_ready_low1", 64'(cfg_ready), 64'd0);
    observe(1);
    check("reconf_ready_low2", 64'(cfg_ready), 64'd0);
    observe(1);
    check("reconf_ready_back", 64'(cfg_ready), 64'd1);
    observe(6);
    check("reconf_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_run();

    // Transfer on a wrap cycle is deferred to the following wrap
    cfg_write(32'd4, 1'b0);
    pulse_start(s);
    push_ev(s + 4, 1'b1, 1'b0);
    push_ev(s + 8, 1'b0, 1'b0);
    push_ev(s + 10, 1'b1, 1'b0);
    push_ev(s + 12, 1'b0, 1'b0);
    observe(3);
    cfg_valid = 1'b1;
    cfg_half  = 32'd2;
    observe(1);
    cfg_valid = 1'b0;
    check("wrapxfer_pending", 64'(cfg_ready), 64'd0);
    observe(4);
    check("wrapxfer_ready", 64'(cfg_ready), 64'd1);
    observe(4);
    check("wrapxfer_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_run();

    // One-shot, half = 3
    cfg_write(32'd3, 1'b1);
    pulse_start(s);
    push_ev(s + 3, 1'b1, 1'b0);
    push_ev(s + 6, 1'b0, 1'b1);
    observe(4);
    check("oneshot_high_c4", 64'(clk_out), 64'd1);
    observe(1);
    check("oneshot_high_c5", 64'(clk_out), 64'd1);
    observe(3);
    check("oneshot_busy_end", 64'(busy), 64'd0);
    check("oneshot_clk_low", 64'(clk_out), 64'd0);
    check("oneshot_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stop on the wrap cycle, then restart from cnt = 0
    cfg_write(32'd5, 1'b0);
    pulse_start(s);
    observe(4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stopwrap_tick", 64'(tick), 64'd0);
    check("stopwrap_busy", 64'(busy), 64'd0);
    check("stopwrap_clk_out", 64'(clk_out), 64'd0);
    pulse_start(s2);
    push_ev(s2 + 5, 1'b1, 1'b0);
    observe(5);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_run();

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    observe(2);
    check("startstop_busy", 64'(busy), 64'd0);
    start = 1'b0;
    stop  = 1'b0;

    // Asynchronous reset mid-run
    cfg_write(32'd1, 1'b0);
    pulse_start(s);
    push_ev(s + 1, 1'b1, 1'b0);
    observe(1);
    check("prereset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tick", 64'(tick), 64'd0);
    check("async_clk_out", 64'(clk_out), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("postreset_ready", 64'(cfg_ready), 64'd1);
    pulse_start(s);
    push_ev(s + DefHalf, 1'b1, 1'b0);
    observe(DefHalf);
    check("postreset_queue_empty", 64'(exp_q.size()), 64'd0);
    stop_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Run-time controller for the board's clock-division datapath. Holds a programmable half-period, starts and stops division on command, and produces a divided clock plus a one-cycle tick enable. A valid/ready handshake lets a host change the ratio, including during operation, without glitches. It sits between control logic (buttons, FSMs) and the time-base consumers (counters, display scanners).

Parameters:
W, 32, width of the half-period count and config bus
DEFAULT_HALF, 50_000_000, half-period in clk cycles after reset (1 Hz at 100 MHz)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  host offers a new configuration
cfg_ready  out  1  block can accept a configuration this cycle
cfg_half  in  W  new half-period in clk cycles; 0 is treated as 1
cfg_oneshot  in  1  1 = single output period then stop; 0 = free-run
start  in  1  level-sampled start request
stop  in  1  level-sampled stop request
busy  out  1  high while dividing
clk_out  out  1  divided clock, period 2*half
tick  out  1  one-cycle pulse at every clk_out edge
done  out  1  one-cycle pulse when a one-shot completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- State on reset: state IDLE, half_reg=DEFAULT_HALF, oneshot_reg=0, cnt=0, edge_cnt=0, pending=0.
- Outputs on reset: clk_out=0, tick=0, done=0, busy=0, cfg_ready=1.
- FSM has two states, IDLE and RUN. busy = (state==RUN), combinational from the state register.
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready = !pending, combinational.
- Transfer in IDLE: half_reg and oneshot_reg load on the next edge. pending stays 0.
- Transfer in RUN: cfg_half and cfg_oneshot are captured in shadow registers and pending is set.
- IDLE -> RUN: on start && !stop. Next cycle cnt=0, edge_cnt=0, clk_out=0.
- RUN counting:
  - cnt increments each cycle.
  - When cnt == half_reg-1 (wrap): cnt<=0, clk_out toggles, tick<=1 for exactly that one registered cycle, edge_cnt increments.
  - tick spacing is exactly half_reg cycles. First tick arrives half_reg cycles after the RUN entry edge.
- Reconfiguration: if pending at a wrap, shadow values move into half_reg/oneshot_reg on the same edge and pending clears. The new ratio governs the next half-period, so there are no runt pulses.
- One-shot: with oneshot_reg=1, the second wrap (edge_cnt 1 -> 2) drives clk_out to 0, pulses done for 1 cycle, and returns to IDLE. tick still pulses on that edge.
- Stop: RUN -> IDLE on the next edge. cnt=0, clk_out=0, no tick, no done. Any pending shadow is applied immediately and pending clears.
- Simultaneous events:
  - stop && start in IDLE: stay IDLE.
  - stop at a wrap cycle: stop wins and no tick is issued.
  - cfg transfer in the same cycle as a wrap while pending=0: the value is captured as pending and applied at the following wrap.
- Width: cnt and half_reg are W bits, compare is unsigned. A cfg_half of 0 is stored as 1, which gives tick every cycle and clk_out = clk/2.
- Async reset mid-run: all registers return to reset values immediately. tick and done drop the same instant.

Decomposition:
- Shared package div_pkg holds: the state enum (IDLE, RUN), the DEFAULT_HALF constant, and W.
- One sub-module, half_counter: cnt register with clear, terminal compare against half_reg, and the toggle/tick generation.
- div_ctrl keeps the FSM, the handshake, the shadow registers and the one-shot logic.

Test Plan:
- Reset then cfg_half=4, free-run, start -> tick every 4 cycles, clk_out period 8 with 50% duty, busy=1, done never asserts.
- RUN with half=4; cfg transfer of half=2 at cnt=1 -> cfg_ready=0 until the next wrap. That half-period stays 4 cycles, later ones are 2. No runt pulse on clk_out.
- cfg_half=3, oneshot=1, start -> ticks at +3 and +6 cycles, clk_out high for cycles 3..5, done pulses at +6, busy falls, state returns to IDLE.
- RUN, half=5; stop asserted on the wrap cycle -> no tick, clk_out=0, busy=0 next cycle. A following start restarts with cnt=0.
- cfg_half=0 -> tick every cycle, clk_out = clk/2. Also: start and stop together in IDLE -> busy stays 0.
- rst_n pulsed low mid-run -> tick, clk_out, busy and done drop to 0 immediately. After release, half_reg=DEFAULT_HALF and cfg_ready=1.
